time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 94 +++++++++
 tb/tb_time_set_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: minute prescaler plus hour/minute edit FSM feeding a BCD time counter chain.
module time_set_ctrl #(
  parameter int TICKS_PER_MIN = 60,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] u_min_cur,
  input  logic [2:0] z_min_cur,
  input  logic [3:0] u_hour_cur,
  input  logic [1:0] z_hour_cur,
  output logic       en,
  output logic       load,
  output logic [3:0] u_min_set,
  output logic [2:0] z_min_set,
  output logic [3:0] u_hour_set,
  output logic [1:0] z_hour_set,
  output logic [1:0] mode,
  output logic       blink
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, COMMIT = 2'd3} state_t;
  state_t state, nextState;
  logic [7:0] prescaler, timeout;
  logic [3:0] uMin, uHour;
  logic [2:0] zMin;
  logic [1:0] zHour;
  logic blinkQ, editing, timedOut, hourOk, minOk, nextEditing;
  assign editing = state == SET_HOUR || state == SET_MIN;
  assign nextEditing = nextState == SET_HOUR || nextState == SET_MIN;
  assign timedOut = editing && tick && !btn_mode && !btn_inc && timeout == 8'(TIMEOUT_TICKS - 1);
  assign hourOk = u_hour_cur <= 4'd9 && (z_hour_cur < 2'd2 || (z_hour_cur == 2'd2 && u_hour_cur <= 4'd3));
  assign minOk = u_min_cur <= 4'd9 && z_min_cur <= 3'd5;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      RUN:      nextState = btn_mode ? SET_HOUR : RUN;
      SET_HOUR: nextState = btn_mode ? SET_MIN : timedOut ? RUN : SET_HOUR;
      SET_MIN:  nextState = btn_mode ? COMMIT : timedOut ? RUN : SET_MIN;
      default:  nextState = RUN;
    endcase
  end
  // en is combinational so the strobe lands in the same cycle as the qualifying tick
  always_comb begin
    en = rst_n && state == RUN && tick && !btn_mode && prescaler == 8'(TICKS_PER_MIN - 1);
    load = state == COMMIT;
    mode = state;
    blink = blinkQ;
    u_min_set = uMin;
    z_min_set = zMin;
    u_hour_set = uHour;
    z_hour_set = zHour;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prescaler <= 8'd0;
      timeout <= 8'd0;
      blinkQ <= 1'b0;
      uMin <= 4'd0;
      zMin <= 3'd0;
      uHour <= 4'd0;
      zHour <= 2'd0;
    end else begin
      blinkQ <= nextEditing ? blinkQ ^ (editing && tick) : 1'b0;
      if (state == COMMIT || en) prescaler <= 8'd0;
      else if (state == RUN && tick && !btn_mode) prescaler <= prescaler + 8'd1;
      if (!editing || btn_mode || btn_inc || timedOut) timeout <= 8'd0;
      else if (tick) timeout <= timeout + 8'd1;
      if (state == RUN && btn_mode) begin
        uHour <= hourOk ? u_hour_cur : 4'd0;
        zHour <= hourOk ? z_hour_cur : 2'd0;
        uMin <= minOk ? u_min_cur : 4'd0;
        zMin <= minOk ? z_min_cur : 3'd0;
      end else if (state == SET_HOUR && btn_inc && !btn_mode) begin
        if (zHour == 2'd2 && uHour == 4'd3) begin
          zHour <= 2'd0;
          uHour <= 4'd0;
        end else if (uHour == 4'd9) begin
          zHour <= zHour + 2'd1;
          uHour <= 4'd0;
        end else uHour <= uHour + 4'd1;
      end else if (state == SET_MIN && btn_inc && !btn_mode) begin
        if (uMin == 4'd9) begin
          uMin <= 4'd0;
          zMin <= zMin == 3'd5 ? 3'd0 : zMin + 3'd1;
        end else uMin <= uMin + 4'd1;
      end
    end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: random and directed stimulus checked every cycle against an arithmetic model of the time-set controller.
module tb_time_set_ctrl;
  localparam int TPM = 60;
  localparam int TO = 30;
  logic clk = 0, rst_n = 1, tick = 0, btn_mode = 0, btn_inc = 0;
  logic [3:0] u_min_cur = 0, u_hour_cur = 0;
  logic [2:0] z_min_cur = 0;
  logic [1:0] z_hour_cur = 0;
  logic en, load, blink;
  logic [3:0] u_min_set, u_hour_set;
  logic [2:0] z_min_set;
  logic [1:0] z_hour_set, mode;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  time_set_ctrl #(.TICKS_PER_MIN(TPM), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .u_min_cur(u_min_cur), .z_min_cur(z_min_cur), .u_hour_cur(u_hour_cur), .z_hour_cur(z_hour_cur),
    .en(en), .load(load), .u_min_set(u_min_set), .z_min_set(z_min_set),
    .u_hour_set(u_hour_set), .z_hour_set(z_hour_set), .mode(mode), .blink(blink)
  );
  typedef struct {int st; int pre; int to; int hr; int mn; bit bl;} mdl_t;
  mdl_t m;
  // st uses the mode numbering; hr/mn are plain integers 0..23 / 0..59
  function automatic mdl_t step(mdl_t s, bit t, bit bm, bit bi);
    mdl_t n = s;
    int ch = z_hour_cur * 10 + u_hour_cur;
    int cm = z_min_cur * 10 + u_min_cur;
    if (s.st == 0) begin
      if (bm) begin
        n.st = 1;
        n.to = 0;
        n.hr = (u_hour_cur <= 9 && ch <= 23) ? ch : 0;
        n.mn = (u_min_cur <= 9 && z_min_cur <= 5) ? cm : 0;
      end else if (t) n.pre = (s.pre + 1) % TPM;
    end else if (s.st == 3) begin
      n.st = 0;
      n.pre = 0;
      n.to = 0;
    end else if (bm) begin
      n.st = s.st + 1;
      n.to = 0;
    end else if (bi) begin
      n.to = 0;
      if (s.st == 1) n.hr = (s.hr + 1) % 24;
      else n.mn = (s.mn + 1) % 60;
    end else if (t) begin
      n.to = s.to + 1;
      if (n.to == TO) begin
        n.st = 0;
        n.to = 0;
      end
    end
    n.bl = (n.st == 1 || n.st == 2) ? s.bl ^ (t && (s.st == 1 || s.st == 2)) : 1'b0;
    return n;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= '{default: 0};
    else m <= step(m, tick, btn_mode, btn_inc);
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) begin
    check("en", int'(en), int'(m.st == 0 && tick && !btn_mode && m.pre == TPM - 1));
    check("load", int'(load), int'(m.st == 3));
    check("mode", int'(mode), m.st);
    check("blink", int'(blink), int'(m.bl));
    check("u_hour_set", int'(u_hour_set), m.hr % 10);
    check("z_hour_set", int'(z_hour_set), m.hr / 10);
    check("u_min_set", int'(u_min_set), m.mn % 10);
    check("z_min_set", int'(z_min_set), m.mn / 10);
  end
  task automatic cyc(input bit t, input bit bm, input bit bi);
    @(posedge clk);
    #1;
    tick = t;
    btn_mode = bm;
    btn_inc = bi;
    #2;
  endtask
  task automatic setCur(input int h, input int mi);
    u_hour_cur = 4'(h % 10);
    z_hour_cur = 2'(h / 10);
    u_min_cur = 4'(mi % 10);
    z_min_cur = 3'(mi / 10);
  endtask
  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 0;
    tick = 0;
    btn_mode = 0;
    btn_inc = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    #2;
  endtask
  initial begin
    int enTicks[$];
    int found;
    bit sawLoad;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #2;
    check("reset mode", int'(mode), 0);
    check("reset en", int'(en), 0);
    check("reset load", int'(load), 0);
    check("reset blink", int'(blink), 0);
    check("reset set", int'({z_hour_set, u_hour_set, z_min_set, u_min_set}), 0);
    for (int k = 1; k <= 120; k++) begin
      cyc(1, 0, 0);
      if (en) enTicks.push_back(k);
    end
    check("en count", enTicks.size(), 2);
    check("en first tick", enTicks.size() > 0 ? enTicks[0] : -1, 60);
    check("en second tick", enTicks.size() > 1 ? enTicks[1] : -1, 120);
    setCur(23, 58);
    cyc(0, 1, 0);
    check("seq capture mode", int'(mode), 0);
    cyc(0, 0, 1);
    check("seq mode 1", int'(mode), 1);
    cyc(0, 1, 0);
    check("hour wrap 23->00", int'({z_hour_set, u_hour_set}), 0);
    cyc(0, 0, 1);
    check("seq mode 2", int'(mode), 2);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("seq mode 3", int'(mode), 3);
    check("commit load", int'(load), 1);
    check("commit set 00:01", int'({z_hour_set, u_hour_set, z_min_set, u_min_set}), 1);
    cyc(0, 0, 0);
    check("seq mode 0", int'(mode), 0);
    check("load one cycle", int'(load), 0);
    setCur(22, 59);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("min wrap 59->00", int'({z_min_set, u_min_set}), 0);
    check("min wrap hour kept", int'({z_hour_set, u_hour_set}), 'h22);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    setCur(9, 30);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("hour 09->10", int'({z_hour_set, u_hour_set}), 'h10);
    check("hour inc min kept", int'({z_min_set, u_min_set}), 'h30);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    setCur(12, 34);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    check("mode+inc -> SET_MIN", int'(mode), 2);
    check("mode+inc hour kept", int'({z_hour_set, u_hour_set}), 'h12);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    doReset();
    repeat (10) cyc(1, 0, 0);
    cyc(0, 1, 0);
    sawLoad = 0;
    for (int k = 0; k < TO; k++) begin
      cyc(1, 0, 0);
      if (load) sawLoad = 1;
    end
    cyc(0, 0, 0);
    check("timeout mode", int'(mode), 0);
    check("timeout no load", int'(sawLoad || load), 0);
    found = -1;
    for (int k = 1; k <= 100; k++) begin
      cyc(1, 0, 0);
      if (en) begin
        found = k;
        break;
      end
    end
    check("resume en tick", found, 50);
    setCur(17, 45);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("pre-reset SET_MIN", int'(mode), 2);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("async reset mode", int'(mode), 0);
    check("async reset load", int'(load), 0);
    check("async reset blink", int'(blink), 0);
    check("async reset set", int'({z_hour_set, u_hour_set, z_min_set, u_min_set}), 0);
    @(posedge clk);
    #1 rst_n = 1;
    #2;
    for (int seg = 0; seg < 8; seg++) begin
      for (int k = 0; k < 400; k++) begin
        bit lo = seg[0];
        cyc(1'($urandom_range(0, 1)),
            lo ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 19) == 0),
            lo ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 5) == 0));
        u_hour_cur = 4'($urandom);
        z_hour_cur = 2'($urandom);
        u_min_cur = 4'($urandom);
        z_min_cur = 3'($urandom);
        if ($urandom_range(0, 599) == 0) begin
          rst_n = 0;
          #1 rst_n = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
